// File: rtl/value_demux_loader.sv
// Operand loader: steers a valid/ready word stream alternately into two
// held operand slots and presents each completed pair downstream.
module value_demux_loader #(
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clear,
    output logic [WIDTH-1:0]     Output0,
    output logic [WIDTH-1:0]     Output1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 fill_sel,
    output logic [CNT_WIDTH-1:0] pair_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     out0_q, out0_d;
    logic [WIDTH-1:0]     out1_q, out1_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_xfer;
    logic                 out_xfer;

    // Handshake decode: a held pair only frees the input when it is consumed
    always_comb begin
        in_ready = !clear && (state_q != FULL || out_ready);
        in_xfer  = in_valid && in_ready;
        out_xfer = (state_q == FULL) && out_ready && !clear;
    end

    // Next-state steering of the incoming word into slot 0 or slot 1
    always_comb begin
        state_d = state_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        out0_d  = in_data;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (in_xfer) begin
                        out1_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (in_xfer) begin
                            out0_d  = in_data;
                            state_d = HALF;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, operand slots and pair counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            out0_q  <= '0;
            out1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come from registered state only
    always_comb begin
        Output0    = out0_q;
        Output1    = out1_q;
        out_valid  = (state_q == FULL);
        fill_sel   = (state_q == HALF);
        pair_count = cnt_q;
    end

endmodule

// File: tb/tb_value_demux_loader.sv
// Scoreboard bench for value_demux_loader: a word-level model predicts
// handshakes and pairs; a monitor checks every consumed pair.
module tb_value_demux_loader;

    logic       clk;
    logic       reset_n;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [4:0] Output0;
    logic [4:0] Output1;
    logic       out_valid;
    logic       out_ready;
    logic       fill_sel;
    logic [7:0] pair_count;

    value_demux_loader #(.WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .clear(clear),
        .Output0(Output0),
        .Output1(Output1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill_sel(fill_sel),
        .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: words accepted since the last flush, plus a held pair
    int       m_partial;
    bit       m_held;
    bit [4:0] m_o0, m_o1;
    int       m_cnt;
    bit [9:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_partial = 0;
        m_held    = 0;
        m_o0      = 0;
        m_o1      = 0;
        m_cnt     = 0;
        exp_q.delete();
    endtask

    // Drives one cycle (called just after a rising edge), checks the
    // visible state at the falling edge, then advances the model.
    task automatic cycle(input bit v, input bit [4:0] d,
                         input bit c, input bit r);
        bit er, ix, ox;
        in_valid  = v;
        in_data   = d;
        clear     = c;
        out_ready = r;
        @(negedge clk);
        er = !c && (!m_held || r);
        chk("in_ready", int'(in_ready), int'(er));
        chk("out_valid", int'(out_valid), int'(m_held));
        chk("fill_sel", int'(fill_sel), int'(!m_held && m_partial == 1));
        chk("Output0", int'(Output0), int'(m_o0));
        chk("Output1", int'(Output1), int'(m_o1));
        chk("pair_count", int'(pair_count), m_cnt % 256);
        ix = v && er;
        ox = m_held && r && !c;
        if (c) begin
            if (m_held) void'(exp_q.pop_back());
            m_held    = 0;
            m_partial = 0;
        end else begin
            if (ox) begin
                m_held = 0;
                m_cnt++;
            end
            if (ix) begin
                if (m_partial == 0) begin
                    m_o0      = d;
                    m_partial = 1;
                end else begin
                    m_o1      = d;
                    m_partial = 0;
                    m_held    = 1;
                    exp_q.push_back({m_o0, d});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed pair must match the oldest expected pair
    initial begin
        bit [9:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    chk("pair_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_out0", int'(Output0), int'(e[9:5]));
                    chk("pair_out1", int'(Output1), int'(e[4:0]));
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fill_sel", int'(fill_sel), 0);
        chk("rst_Output0", int'(Output0), 0);
        chk("rst_Output1", int'(Output1), 0);
        chk("rst_pair_count", int'(pair_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset_n = 1'b1;

        // Basic pair, then back-pressure and pass-through
        cycle(1, 5'd3, 0, 0);
        cycle(1, 5'd17, 0, 0);
        repeat (3) cycle(1, 5'd0, 0, 0);
        cycle(1, 5'd31, 0, 1);
        cycle(0, 5'd0, 0, 0);
        cycle(1, 5'd2, 0, 1);
        cycle(0, 5'd0, 0, 1);

        // Streaming words 0..19 with the consumer always ready
        for (int i = 0; i < 20; i++) cycle(1, 5'(i), 0, 1);
        cycle(0, 5'd0, 0, 1);

        // Clear in HALF and in FULL
        cycle(1, 5'd9, 0, 0);
        cycle(1, 5'd4, 1, 0);
        cycle(0, 5'd0, 0, 0);
        cycle(1, 5'd6, 0, 0);
        cycle(1, 5'd7, 0, 0);
        cycle(1, 5'd8, 1, 1);
        cycle(0, 5'd0, 0, 1);

        // Sustained streaming long enough to wrap the pair counter
        for (int i = 0; i < 560; i++) cycle(1, 5'($urandom), 0, 1);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0));

        // Async reset while a pair is held
        cycle(0, 5'd0, 1, 0);
        cycle(1, 5'd21, 0, 0);
        cycle(1, 5'd22, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_Output0", int'(Output0), 0);
        chk("arst_Output1", int'(Output1), 0);
        chk("arst_pair_count", int'(pair_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1, 5'd11, 0, 0);
        cycle(1, 5'd12, 0, 0);
        cycle(0, 5'd0, 0, 1);
        cycle(0, 5'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/value_demux_loader.md
# value_demux_loader

Operand loader for the ALU datapath: accepts a stream of 5-bit values over a valid/ready handshake and demultiplexes them alternately into two held operand registers, Output0 then Output1. Once both slots are filled it presents the pair to the downstream 2:1 value selector and ALU with a valid/ready handshake. It is the write-side counterpart of the operand mux: the mux picks one of two values, this block steers one input into one of two values.

## Interface
- WIDTH, 5, operand width in bits
- CNT_WIDTH, 8, width of the completed-pair counter
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  incoming operand value
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader accepts in_data this cycle
- clear  input  1  synchronous flush; discards a partial or complete pair
- Output0  output  WIDTH  operand slot 0, registered
- Output1  output  WIDTH  operand slot 1, registered
- out_valid  output  1  Output0/Output1 hold a complete pair
- out_ready  input  1  consumer takes the pair this cycle
- fill_sel  output  1  slot the next accepted word is written to (0 or 1)
- pair_count  output  CNT_WIDTH  number of pairs consumed, wraps modulo 2^CNT_WIDTH

## Operation
- States: EMPTY (slot 0 next), HALF (slot 1 next), FULL (pair held).
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready && !clear`.
- `in_ready = !clear && (state != FULL || out_ready)`. This is combinational from clear and out_ready.
- `out_valid = (state == FULL)`. `fill_sel = (state == HALF)`. Both are decoded from registered state only.
- EMPTY with an input transfer: `Output0 <= in_data`, go to HALF.
- HALF with an input transfer: `Output1 <= in_data`, go to FULL.
- FULL with an output transfer:
  - pair_count increments.
  - If an input transfer occurs in the same cycle: `Output0 <= in_data`, go to HALF (pass-through, no bubble).
  - Otherwise go to EMPTY.
- FULL without out_ready: hold. in_ready is 0 and both slots are stable.
- clear has highest priority:
  - Next state is EMPTY.
  - No input transfer and no output transfer occur in that cycle, and pair_count does not change.
  - Output0/Output1 keep their old contents. out_valid drops on the next cycle.
- Output0/Output1 change only on a write to that slot. Slot 1 is not cleared when a new slot-0 write occurs.
- pair_count wraps from 2^CNT_WIDTH−1 to 0 without any flag.
- in_data is sampled only on an input transfer. It is a don't-care otherwise.

## Timing
- Reset (async assert, released synchronously by the system):
  - state = EMPTY, Output0 = 0, Output1 = 0, pair_count = 0.
  - out_valid = 0, fill_sel = 0, in_ready = !clear.
- Asserting reset mid-pair discards all progress immediately, without waiting for a clock edge.
- Latency: out_valid rises in the cycle after the edge that accepts the second word of a pair.
- Throughput:
  - Sustained 1 word per cycle and 1 pair per 2 cycles when out_ready is held at 1.
  - In FULL, the consume and the next slot-0 write happen on the same edge.
- No combinational path from in_valid or in_data to any output. in_ready depends combinationally on out_ready and clear only.

## Test plan
- Reset then basic pair:
  - Stimulus: assert reset_n=0 with clk running, then release. Send 5'd3 then 5'd17 with in_valid=1 and out_ready=0.
  - Response: during reset all outputs are 0. After release, fill_sel goes 0→1→0 and Output0=3, Output1=17. out_valid=1 one cycle after 17 is accepted, and in_ready=0 while FULL.
- Back-pressure then pass-through:
  - Stimulus: in FULL with (3,17), hold out_ready=0 for 3 cycles, then pulse out_ready=1 with in_data=5'd31 and in_valid=1.
  - Response: Output0/Output1 are stable while held. On the pulse edge pair_count 0→1, state goes to HALF, Output0=31, Output1 still 17, and out_valid=0.
- Streaming:
  - Stimulus: 20 consecutive words 0..19 with in_valid=1 and out_ready=1.
  - Response: 10 pairs observed, (0,1),(2,3)…(18,19), with out_valid high every other cycle and final pair_count=10.
- Clear:
  - Stimulus: in HALF with Output0=9, assert clear for 1 cycle with in_valid=1 and in_data=4.
  - Response: in_ready=0 during clear, the word is not taken, state goes to EMPTY, and Output0 stays 9. Assert clear in FULL with out_ready=1: pair_count is unchanged.
- Counter wrap:
  - Stimulus: consume 256 pairs.
  - Response: pair_count goes 255→0 on the 256th consume, with no other side effect.
- Async reset mid-pair:
  - Stimulus: assert reset_n low between clock edges while in FULL.
  - Response: out_valid, Output0, Output1 and pair_count go to 0 before the next edge. The next accepted word goes to slot 0.
